// File: rtl/spine_switch_rr.sv
`timescale 1ns/1ps
// spine_switch_rr: leaf/spine/group router with a FIFO per input, destination-decoded
// routing, a round-robin arbiter per output and saturating illegal-destination drop count.
module spine_switch_rr #(
  parameter int GROUP_ID   = 3,
  parameter int NUM_LEAF   = 4,
  parameter int NUM_GROUPS = 8,
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int NUM_PORTS = NUM_LEAF + NUM_GROUPS - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*DWIDTH-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS*DWIDTH-1:0]   out_data,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS*DWIDTH-1:0]    head_flat;
  logic [NUM_PORTS*PW-1:0]        head_target;
  logic [NUM_PORTS*NUM_PORTS-1:0] grant_flat;
  logic [NUM_PORTS-1:0]           not_empty;
  logic [NUM_PORTS-1:0]           legal;
  logic [NUM_PORTS-1:0]           head_valid;
  logic [NUM_PORTS-1:0]           drop;
  logic [NUM_PORTS-1:0]           pop;
  logic [15:0]                    drop_count_reg;
  logic [15:0]                    drop_count_next;
  logic [16:0]                    drop_sum;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
      logic [DWIDTH-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]     wr_ptr_reg;
      logic [AW-1:0]     rd_ptr_reg;
      logic [CW-1:0]     count_reg;
      logic              push;
      logic [DWIDTH-1:0] head;
      logic [3:0]        dest_group;
      logic [3:0]        dest_leaf;
      logic [PW-1:0]     target;
      logic              legal_l;

      assign in_ready[gi]  = reset && (count_reg != CW'(FIFO_DEPTH));
      assign push          = in_valid[gi] && in_ready[gi];
      assign not_empty[gi] = (count_reg != '0);
      assign head          = mem[rd_ptr_reg];
      assign head_flat[gi*DWIDTH +: DWIDTH] = head;
      assign dest_group    = head[DWIDTH-1 -: 4];
      assign dest_leaf     = head[DWIDTH-5 -: 4];

      // Storage carries no reset; emptiness is defined purely by the pointers/count.
      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_data[gi*DWIDTH +: DWIDTH];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push)    wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + AW'(1);
          case ({push, pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: ;
          endcase
        end
      end

      // Local group goes to the leaf; other groups skip our own group number.
      always_comb begin
        legal_l = 1'b1;
        target  = '0;
        if (int'(dest_group) >= NUM_GROUPS) begin
          legal_l = 1'b0;
        end else if (int'(dest_group) == GROUP_ID) begin
          if (int'(dest_leaf) >= NUM_LEAF) legal_l = 1'b0;
          else                             target  = PW'(dest_leaf);
        end else if (int'(dest_group) < GROUP_ID) begin
          target = PW'(NUM_LEAF + int'(dest_group));
        end else begin
          target = PW'(NUM_LEAF + int'(dest_group) - 1);
        end
      end

      assign legal[gi] = legal_l;
      assign head_target[gi*PW +: PW] = target;
    end
  endgenerate

  assign head_valid = not_empty & legal;
  assign drop       = not_empty & ~legal;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
      logic [NUM_PORTS-1:0] req;
      logic [NUM_PORTS-1:0] gnt;
      logic [PW-1:0]        rr_ptr_reg;
      logic [PW-1:0]        rr_ptr_next;
      logic [DWIDTH-1:0]    data_reg;
      logic [DWIDTH-1:0]    gnt_data;
      logic                 valid_reg;
      logic                 can_accept;
      logic                 found;

      assign can_accept = !valid_reg || out_ready[gi];

      always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++)
          req[i] = head_valid[i] && (head_target[i*PW +: PW] == PW'(gi));
      end

      // Two passes give the cyclic search: indices at/after the pointer, then the wrap.
      always_comb begin
        found       = 1'b0;
        gnt         = '0;
        gnt_data    = '0;
        rr_ptr_next = rr_ptr_reg;
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (can_accept && !found && req[i] && (i >= int'(rr_ptr_reg))) begin
            found       = 1'b1;
            gnt[i]      = 1'b1;
            gnt_data    = head_flat[i*DWIDTH +: DWIDTH];
            rr_ptr_next = (i == NUM_PORTS-1) ? '0 : PW'(i + 1);
          end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (can_accept && !found && req[i]) begin
            found       = 1'b1;
            gnt[i]      = 1'b1;
            gnt_data    = head_flat[i*DWIDTH +: DWIDTH];
            rr_ptr_next = (i == NUM_PORTS-1) ? '0 : PW'(i + 1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg  <= 1'b0;
          data_reg   <= '0;
          rr_ptr_reg <= '0;
        end else if (can_accept) begin
          valid_reg <= found;
          if (found) begin
            data_reg   <= gnt_data;
            rr_ptr_reg <= rr_ptr_next;
          end
        end
      end

      assign out_valid[gi]                    = valid_reg;
      assign out_data[gi*DWIDTH +: DWIDTH]    = data_reg;
      assign grant_flat[gi*NUM_PORTS +: NUM_PORTS] = gnt;
    end
  endgenerate

  // Each head targets one output, so OR-ing the grant columns never double-pops.
  always_comb begin
    pop = drop;
    for (int o = 0; o < NUM_PORTS; o++)
      pop = pop | grant_flat[o*NUM_PORTS +: NUM_PORTS];
  end

  always_comb begin
    drop_sum = {1'b0, drop_count_reg};
    for (int i = 0; i < NUM_PORTS; i++)
      drop_sum = drop_sum + 17'(drop[i]);
    drop_count_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_count_reg <= '0;
    else        drop_count_reg <= drop_count_next;
  end

  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_spine_switch_rr.sv
`timescale 1ns/1ps
// Directed bench for spine_switch_rr (GROUP_ID=3, 4 leaves, 8 groups -> 11 ports):
// routing, latency, round-robin fairness, backpressure, drop saturation, mid-run reset.
module tb_spine_switch_rr;

  localparam int NP = 11;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [NP*DW-1:0]  out_data;
  logic [NP-1:0]     out_valid;
  logic [NP-1:0]     out_ready;
  logic [15:0]       drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc;
  int stalled;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          cyc;
  } cap_t;
  cap_t cap_q[$];

  always #5 clk = ~clk;

  spine_switch_rr #(
    .GROUP_ID(3), .NUM_LEAF(4), .NUM_GROUPS(8), .DWIDTH(16), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] od(input int p);
    return out_data[p*DW +: DW];
  endfunction

  // Every egress handshake that will complete on the coming edge is logged.
  always @(negedge clk) begin
    for (int o = 0; o < NP; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        cap_t e;
        e.port = o;
        e.data = od(o);
        e.cyc  = cyc;
        cap_q.push_back(e);
        $display("egress port %0d data 0x%04h cycle %0d", o, od(o), cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic [15:0] d);
    in_data[p*DW +: DW] = d;
  endtask

  initial begin
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_data", 32'(|out_data), 32'h0);
    check_eq("rst_drop_count", 32'(drop_count), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 32'(in_ready), 32'h7FF);

    // Local then remote routing, exact latency
    out_ready = '1;
    step();
    set_in(0, 16'h3200); in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0; set_in(1, 16'h5000); in_valid[1] = 1'b1;
    @(negedge clk);
    check_eq("route_not_early", 32'(out_valid), 32'h0);
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check_eq("route_local_valid", 32'(out_valid), 32'h004);
    check_eq("route_local_data", 32'(od(2)), 32'h3200);
    @(negedge clk);
    check_eq("route_remote_valid", 32'(out_valid), 32'h100);
    check_eq("route_remote_data", 32'(od(8)), 32'h5000);
    check_eq("route_local_hold", 32'(od(2)), 32'h3200);

    // Fairness: ports 0,1,2 -> leaf 3, four flits each
    repeat (3) step();
    cap_q.delete();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 3; p++) set_in(p, {8'h33, 4'(p), 4'(k)});
      in_valid[2:0] = 3'b111;
      step();
    end
    in_valid = '0;
    repeat (16) step();
    check_eq("fair_count", 32'(cap_q.size()), 32'd12);
    for (int j = 0; j < cap_q.size() && j < 12; j++) begin
      check_eq($sformatf("fair_port_%0d", j), 32'(cap_q[j].port), 32'd3);
      check_eq($sformatf("fair_data_%0d", j), 32'(cap_q[j].data), 32'({8'h33, 4'(j % 3), 4'(j / 3)}));
      check_eq($sformatf("fair_cycle_%0d", j), 32'(cap_q[j].cyc - cap_q[0].cyc), 32'(j));
    end

    // Backpressure: port 0 streams to group 0 (port 4) while port 4 is stalled
    cap_q.delete();
    out_ready[4] = 1'b0;
    acc = 0;
    stalled = 0;
    set_in(0, 16'h0000); in_valid[0] = 1'b1;
    for (int c = 0; c < 30 && stalled == 0; c++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        step();
        acc++;
        set_in(0, 16'(acc));
      end else begin
        stalled = 1;
      end
    end
    check_eq("bp_stalled", 32'(stalled), 32'd1);
    check_eq("bp_accepts", 32'(acc), 32'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp_hold_valid_%0d", c), 32'(out_valid[4]), 32'd1);
      check_eq($sformatf("bp_hold_data_%0d", c), 32'(od(4)), 32'h0000);
      check_eq($sformatf("bp_full_%0d", c), 32'(in_ready[0]), 32'd0);
    end
    step();
    in_valid[0] = 1'b0;
    out_ready[4] = 1'b1;
    @(negedge clk);
    check_eq("bp_still_full", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    check_eq("bp_ready_after_pop", 32'(in_ready[0]), 32'd1);
    repeat (12) step();
    check_eq("bp_count", 32'(cap_q.size()), 32'd9);
    for (int j = 0; j < cap_q.size() && j < 9; j++) begin
      check_eq($sformatf("bp_port_%0d", j), 32'(cap_q[j].port), 32'd4);
      check_eq($sformatf("bp_data_%0d", j), 32'(cap_q[j].data), 32'(j));
    end

    // Drop accounting: group 9 and local leaf 5 are both illegal
    repeat (2) step();
    cap_q.delete();
    set_in(0, 16'h9000); set_in(1, 16'h3500); in_valid[1:0] = 2'b11;
    step();
    in_valid = '0;
    repeat (4) step();
    @(negedge clk);
    check_eq("drop_count_2", 32'(drop_count), 32'd2);
    check_eq("drop_no_egress", 32'(cap_q.size()), 32'd0);
    for (int p = 0; p < NP; p++) set_in(p, 16'hF000);
    in_valid = '1;
    repeat (3) step();
    in_valid = '0;
    repeat (3) step();
    @(negedge clk);
    check_eq("drop_count_35", 32'(drop_count), 32'd35);
    in_valid = '1;
    acc = 0;
    for (int c = 0; c < 6400; c++) begin
      @(negedge clk);
      acc += $countones(in_valid & in_ready);
    end
    step();
    in_valid = '0;
    check_eq("sat_forced", 32'(acc >= 70000), 32'd1);
    repeat (4) step();
    @(negedge clk);
    check_eq("sat_value", 32'(drop_count), 32'hFFFF);
    repeat (3) step();
    @(negedge clk);
    check_eq("sat_hold", 32'(drop_count), 32'hFFFF);
    check_eq("sat_no_egress", 32'(cap_q.size()), 32'd0);

    // Mid-operation reset with flits buffered toward stalled leaf 1
    out_ready = '0;
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(0, {8'h31, 8'(k)});
      in_valid[0] = 1'b1;
      step();
    end
    in_valid[0] = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check_eq("mrst_pre_valid", 32'(out_valid), 32'h002);
    #1 reset = 1'b0;
    #1;
    check_eq("mrst_out_valid", 32'(out_valid), 32'h0);
    check_eq("mrst_out_data", 32'(|out_data), 32'h0);
    check_eq("mrst_in_ready", 32'(in_ready), 32'h0);
    check_eq("mrst_drop_count", 32'(drop_count), 32'h0);
    repeat (2) step();
    cap_q.delete();
    reset = 1'b1;
    out_ready = '1;
    repeat (8) step();
    @(negedge clk);
    check_eq("mrst_no_stale", 32'(cap_q.size()), 32'd0);
    check_eq("mrst_in_ready_after", 32'(in_ready), 32'h7FF);
    check_eq("mrst_out_valid_after", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
